prmcu_uart_rx_os: RTL and testbench

//  Oversampling UART receiver with runtime frame format, majority-vote sampling, per-frame

---
 rtl/prmcu_uart_rx_os_if.sv | 22 ++
 rtl/prmcu_uart_rx_os.sv | 180 ++++++++++++++++++
 tb/tb_prmcu_uart_rx_os.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prmcu_uart_rx_os_if.sv
// Output handshake bundle of the oversampling UART receiver.
// Master drives data/valid, slave drives ready.
interface prmcu_uart_rx_os_if;
    logic [8:0] out_dat_o;
    logic [2:0] out_err_o;
    logic       out_vld_o;
    logic       out_rdy_i;

    modport master (
        output out_dat_o,
        output out_err_o,
        output out_vld_o,
        input  out_rdy_i
    );

    modport slave (
        input  out_dat_o,
        input  out_err_o,
        input  out_vld_o,
        output out_rdy_i
    );
endinterface

// File: rtl/prmcu_uart_rx_os.sv
// Oversampling UART receiver: majority-vote bit sampling,
// runtime frame format, break detect and output FIFO.
module prmcu_uart_rx_os #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_en,
    input  logic [3:0]                  n_data_bits_i,
    input  logic [1:0]                  parity_mode_i,
    input  logic [1:0]                  n_stop_bits_i,
    input  logic [DIV_W-1:0]            internal_clk_divider_i,
    input  logic                        rx_i,
    prmcu_uart_rx_os_if.master          out_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic                        overflow_o,
    input  logic                        ovf_clr_i
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t state, nxt;

    logic [2:0]       rx_sync;
    logic             rx_s, fall;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick, mid, bit_end, maj, perr;
    logic [SW-1:0]    s_cnt;
    logic [1:0]       samp;
    logic [3:0]       bit_idx, nlast_q, cfg_last;
    logic [8:0]       data_q;
    logic             par_q, ferr_q, stop_idx;
    logic             par_en_q, par_odd_q, two_stop_q;
    logic             push;
    logic [2:0]       push_err;

    logic [11:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop, full, wr_ok;

    assign rx_s = rx_sync[1];
    assign fall = rx_sync[2] & ~rx_sync[1];
    assign cfg_last = (n_data_bits_i >= 4'd5 && n_data_bits_i <= 4'd9)
                    ? n_data_bits_i - 4'd1 : 4'd7;

    // Two-FF synchroniser plus one delay stage for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_sync <= 3'b111;
        else      rx_sync <= {rx_sync[1:0], rx_i};
    end

    // Sample tick generator, idle outside a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       tick_cnt <= '0;
        else if (state == IDLE || !rx_en) tick_cnt <= '0;
        else if (tick_cnt == '0)        tick_cnt <= internal_clk_divider_i;
        else                            tick_cnt <= tick_cnt - DIV_W'(1);
    end

    assign tick    = rx_en && state != IDLE && tick_cnt == '0;
    assign mid     = tick && s_cnt == SW'(OVERSAMPLE / 2 + 1);
    assign bit_end = tick && s_cnt == SW'(OVERSAMPLE - 1);
    assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign perr    = par_en_q && (par_q != (^data_q ^ par_odd_q));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // FSM next state and frame push decision
    always_comb begin
        nxt      = state;
        push     = 1'b0;
        push_err = 3'b000;
        if (state != IDLE && !rx_en) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (rx_en && fall) nxt = START;
                START: begin
                    if (mid && maj)   nxt = IDLE;
                    else if (bit_end) nxt = DATA;
                end
                DATA: if (bit_end && bit_idx == nlast_q)
                    nxt = par_en_q ? PARITY : STOP;
                PARITY: if (bit_end) nxt = STOP;
                STOP: if (mid) begin
                    if (!stop_idx && !maj && data_q == '0
                        && !(par_en_q && par_q)) begin
                        push     = 1'b1;
                        push_err = 3'b110;
                        nxt      = WAIT_IDLE;
                    end else if (stop_idx == two_stop_q) begin
                        push     = 1'b1;
                        push_err = {1'b0, ferr_q | ~maj, perr};
                        nxt      = IDLE;
                    end
                end
                WAIT_IDLE: if (rx_s) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Frame datapath: sample counter, votes, shift-in, config latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt      <= '0;
            samp       <= 2'b11;
            bit_idx    <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx   <= 1'b0;
            nlast_q    <= 4'd7;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (state == IDLE) begin
            s_cnt    <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            ferr_q   <= 1'b0;
            stop_idx <= 1'b0;
            if (rx_en && fall) begin
                nlast_q    <= cfg_last;
                par_en_q   <= parity_mode_i == 2'b01 || parity_mode_i == 2'b10;
                par_odd_q  <= parity_mode_i == 2'b10;
                two_stop_q <= n_stop_bits_i[1];
            end
        end else if (tick) begin
            s_cnt <= bit_end ? '0 : s_cnt + SW'(1);
            if (s_cnt == SW'(OVERSAMPLE / 2 - 1)) samp[0] <= rx_s;
            if (s_cnt == SW'(OVERSAMPLE / 2))     samp[1] <= rx_s;
            if (mid && state == DATA)             data_q[bit_idx] <= maj;
            if (mid && state == PARITY)           par_q <= maj;
            if (mid && state == STOP && !maj)     ferr_q <= 1'b1;
            if (bit_end && state == DATA)         bit_idx <= bit_idx + 4'd1;
            if (bit_end && state == STOP)         stop_idx <= 1'b1;
        end
    end

    assign pop   = out_if.out_vld_o && out_if.out_rdy_i;
    assign full  = fifo_cnt_o == CW'(FIFO_DEPTH);
    assign wr_ok = push && (!full || pop);

    // Output FIFO with sticky overflow; set beats clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= {push_err, data_q};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt_o <= fifo_cnt_o + CW'(wr_ok) - CW'(pop);
            if (push && full && !pop) overflow_o <= 1'b1;
            else if (ovf_clr_i)       overflow_o <= 1'b0;
        end
    end

    assign out_if.out_vld_o = fifo_cnt_o != '0;
    assign out_if.out_dat_o = mem[rd_ptr][8:0];
    assign out_if.out_err_o = mem[rd_ptr][11:9];
endmodule

// File: tb/tb_prmcu_uart_rx_os.sv
// Directed bench for prmcu_uart_rx_os: formats, errors,
// glitch/break, FIFO overflow, enable and reset behaviour.
`timescale 1ns/1ps
module tb_prmcu_uart_rx_os;
    localparam int BIT = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_en = 1'b1;
    logic [3:0]  n_data_bits_i = 4'd8;
    logic [1:0]  parity_mode_i = 2'b00;
    logic [1:0]  n_stop_bits_i = 2'd1;
    logic [15:0] div = 16'd4;
    logic        rx_i = 1'b1;
    logic [3:0]  fifo_cnt_o;
    logic        overflow_o;
    logic        ovf_clr_i = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    logic [11:0] q[$];

    prmcu_uart_rx_os_if bus ();

    prmcu_uart_rx_os dut (
        .clk                    (clk),
        .rst                    (rst),
        .rx_en                  (rx_en),
        .n_data_bits_i          (n_data_bits_i),
        .parity_mode_i          (parity_mode_i),
        .n_stop_bits_i          (n_stop_bits_i),
        .internal_clk_divider_i (div),
        .rx_i                   (rx_i),
        .out_if                 (bus),
        .fifo_cnt_o             (fifo_cnt_o),
        .overflow_o             (overflow_o),
        .ovf_clr_i              (ovf_clr_i)
    );

    always #50 clk = ~clk;

    // Record every accepted FIFO entry
    always @(negedge clk)
        if (rst && bus.out_vld_o && bus.out_rdy_i)
            q.push_back({bus.out_err_o, bus.out_dat_o});

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input int nb, input logic [1:0] pm, input int ns);
        n_data_bits_i = 4'(nb);
        parity_mode_i = pm;
        n_stop_bits_i = 2'(ns);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input int par,
                              input bit flip, input int ns, input bit bad_stop);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        if (par == 2) p = ~p;
        if (flip) p = ~p;
        rx_i = 1'b0;
        cyc(BIT);
        for (int i = 0; i < nb; i++) begin
            rx_i = d[i];
            cyc(BIT);
        end
        if (par != 0) begin
            rx_i = p;
            cyc(BIT);
        end
        for (int i = 0; i < ns; i++) begin
            rx_i = ~bad_stop;
            cyc(BIT);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.out_rdy_i = 1'b1;
        cyc(5);
        n_total++;
        if (bus.out_vld_o !== 1'b0) $display("FAIL reset_vld got %0b exp 0", bus.out_vld_o);
        else n_pass++;
        n_total++;
        if (bus.out_dat_o !== 9'h000) $display("FAIL reset_dat got %h exp 000", bus.out_dat_o);
        else n_pass++;
        n_total++;
        if (bus.out_err_o !== 3'b000) $display("FAIL reset_err got %b exp 000", bus.out_err_o);
        else n_pass++;
        n_total++;
        if (fifo_cnt_o !== 4'd0) $display("FAIL reset_cnt got %0d exp 0", fifo_cnt_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", overflow_o);
        else n_pass++;
        rst = 1'b1;
        cyc(20);
    endtask

    task automatic test_8n1();
        logic [7:0] b [4];
        logic [11:0] got;
        b = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        q.delete();
        set_cfg(8, 2'b00, 1);
        for (int i = 0; i < 4; i++) begin
            send_frame({1'b0, b[i]}, 8, 0, 1'b0, 1, 1'b0);
            cyc(20);
        end
        n_total++;
        if (q.size() !== 4) $display("FAIL 8n1_count got %0d exp 4", q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            got = (i < q.size()) ? q[i] : 12'hxxx;
            n_total++;
            if (got !== {4'b0000, b[i]})
                $display("FAIL 8n1_word%0d got %h exp %h", i, got, {4'b0000, b[i]});
            else n_pass++;
        end
    endtask

    task automatic test_7e2();
        logic [11:0] got;
        q.delete();
        set_cfg(7, 2'b01, 2);
        send_frame(9'h05A, 7, 1, 1'b1, 2, 1'b0);
        cyc(20);
        send_frame(9'h05A, 7, 1, 1'b0, 2, 1'b0);
        cyc(20);
        n_total++;
        if (q.size() !== 2) $display("FAIL 7e2_count got %0d exp 2", q.size());
        else n_pass++;
        got = (q.size() > 0) ? q[0] : 12'hxxx;
        n_total++;
        if (got !== 12'h25A) $display("FAIL 7e2_badpar got %h exp 25a", got);
        else n_pass++;
        got = (q.size() > 1) ? q[1] : 12'hxxx;
        n_total++;
        if (got !== 12'h05A) $display("FAIL 7e2_goodpar got %h exp 05a", got);
        else n_pass++;
    endtask

    task automatic test_9o1();
        logic [11:0] got;
        q.delete();
        set_cfg(9, 2'b10, 1);
        send_frame(9'h1B5, 9, 2, 1'b0, 1, 1'b0);
        cyc(20);
        send_frame(9'h1B5, 9, 2, 1'b0, 1, 1'b1);
        rx_i = 1'b1;
        cyc(40);
        n_total++;
        if (q.size() !== 2) $display("FAIL 9o1_count got %0d exp 2", q.size());
        else n_pass++;
        got = (q.size() > 0) ? q[0] : 12'hxxx;
        n_total++;
        if (got !== 12'h1B5) $display("FAIL 9o1_good got %h exp 1b5", got);
        else n_pass++;
        got = (q.size() > 1) ? q[1] : 12'hxxx;
        n_total++;
        if (got !== 12'h5B5) $display("FAIL 9o1_badstop got %h exp 5b5", got);
        else n_pass++;
    endtask

    task automatic test_glitch_break();
        logic [11:0] got;
        q.delete();
        set_cfg(8, 2'b00, 1);
        rx_i = 1'b0;
        cyc(3);
        rx_i = 1'b1;
        cyc(200);
        n_total++;
        if (q.size() !== 0) $display("FAIL glitch_push got %0d exp 0", q.size());
        else n_pass++;
        send_frame(9'h000, 8, 0, 1'b0, 1, 1'b1);
        cyc(500);
        n_total++;
        if (q.size() !== 1) $display("FAIL break_count got %0d exp 1", q.size());
        else n_pass++;
        got = (q.size() > 0) ? q[0] : 12'hxxx;
        n_total++;
        if (got !== 12'hC00) $display("FAIL break_entry got %h exp c00", got);
        else n_pass++;
        rx_i = 1'b1;
        cyc(200);
        n_total++;
        if (q.size() !== 1) $display("FAIL break_after got %0d exp 1", q.size());
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [11:0] got;
        q.delete();
        set_cfg(8, 2'b00, 1);
        bus.out_rdy_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_frame(9'(8'h10 + i), 8, 0, 1'b0, 1, 1'b0);
            cyc(20);
        end
        n_total++;
        if (fifo_cnt_o !== 4'd8) $display("FAIL ovf_cnt got %0d exp 8", fifo_cnt_o);
        else n_pass++;
        n_total++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_set got %0b exp 1", overflow_o);
        else n_pass++;
        n_total++;
        if (bus.out_vld_o !== 1'b1 || bus.out_dat_o !== 9'h010)
            $display("FAIL ovf_head got vld %0b dat %h exp 1 010", bus.out_vld_o, bus.out_dat_o);
        else n_pass++;
        ovf_clr_i = 1'b1;
        cyc(1);
        ovf_clr_i = 1'b0;
        n_total++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_clr got %0b exp 0", overflow_o);
        else n_pass++;
        bus.out_rdy_i = 1'b1;
        cyc(12);
        n_total++;
        if (q.size() !== 8) $display("FAIL ovf_drain got %0d exp 8", q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            got = (i < q.size()) ? q[i] : 12'hxxx;
            n_total++;
            if (got !== 12'(8'h10 + i))
                $display("FAIL ovf_word%0d got %h exp %h", i, got, 12'(8'h10 + i));
            else n_pass++;
        end
        n_total++;
        if (fifo_cnt_o !== 4'd0) $display("FAIL ovf_empty got %0d exp 0", fifo_cnt_o);
        else n_pass++;
    endtask

    task automatic test_rx_en();
        logic [11:0] got;
        q.delete();
        set_cfg(8, 2'b00, 1);
        rx_i = 1'b0;
        cyc(4 * BIT + BIT / 2);
        rx_en = 1'b0;
        cyc(2);
        rx_i = 1'b1;
        cyc(100);
        rx_en = 1'b1;
        cyc(20);
        send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b0);
        cyc(20);
        n_total++;
        if (q.size() !== 1) $display("FAIL rxen_count got %0d exp 1", q.size());
        else n_pass++;
        got = (q.size() > 0) ? q[0] : 12'hxxx;
        n_total++;
        if (got !== 12'h03C) $display("FAIL rxen_word got %h exp 03c", got);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.out_rdy_i = 1'b0;
        set_cfg(8, 2'b00, 1);
        send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b0);
        cyc(20);
        n_total++;
        if (bus.out_vld_o !== 1'b1 || bus.out_dat_o !== 9'h0A5)
            $display("FAIL rstmid_pre got vld %0b dat %h exp 1 0a5", bus.out_vld_o, bus.out_dat_o);
        else n_pass++;
        rx_i = 1'b0;
        cyc(200);
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.out_vld_o !== 1'b0) $display("FAIL rstmid_vld got %0b exp 0", bus.out_vld_o);
        else n_pass++;
        n_total++;
        if (bus.out_dat_o !== 9'h000) $display("FAIL rstmid_dat got %h exp 000", bus.out_dat_o);
        else n_pass++;
        n_total++;
        if (bus.out_err_o !== 3'b000) $display("FAIL rstmid_err got %b exp 000", bus.out_err_o);
        else n_pass++;
        n_total++;
        if (fifo_cnt_o !== 4'd0 || overflow_o !== 1'b0)
            $display("FAIL rstmid_cnt got %0d/%0b exp 0/0", fifo_cnt_o, overflow_o);
        else n_pass++;
        cyc(3);
        rx_i = 1'b1;
        rst = 1'b1;
        cyc(5);
    endtask

    initial begin
        bus.out_rdy_i = 1'b1;
        test_reset();
        test_8n1();
        test_7e2();
        test_9o1();
        test_glitch_break();
        test_overflow();
        test_rx_en();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
